// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding and
// default geometry of the external 16-bit asynchronous SRAM.
package sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int unsigned MEM_BASE    = 1024;
   localparam int unsigned SRAM_DATA_W = 16;
   localparam int unsigned SRAM_ADDR_W = 18;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage data-memory request bus: the pipeline is the master, the SRAM
// controller the slave that stalls it through ready.
interface sram_controller_if;

   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output wr_en, rd_en, address, write_data,
      input  read_data, ready
   );

   modport slave (
      input  wr_en, rd_en, address, write_data,
      output read_data, ready
   );

endinterface

// File: rtl/sram_controller.sv
// Services one 32-bit load/store as two 16-bit SRAM accesses (low half, then
// high half), each held ACCESS_CYCLES clocks; ready stays low until done.
module sram_controller
   import sram_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned MEM_BASE      = sram_pkg::MEM_BASE,
   parameter int unsigned SRAM_ADDR_W   = sram_pkg::SRAM_ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst,
   sram_controller_if.slave       req,
   inout  logic [SRAM_DATA_W-1:0] sram_dq,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic                   sram_we_n,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_ub_n,
   output logic                   sram_lb_n
);

   localparam int unsigned CNT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam int unsigned WORD_W = SRAM_ADDR_W - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   wr_q, wr_d;
   logic [WORD_W-1:0]      word_q, word_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [31:0]            rdata_q, rdata_d;

   logic [31:0]            offset;
   logic                   last;
   logic                   drive;
   logic [SRAM_DATA_W-1:0] wr_half;
   logic                   unused_offset_bits;

   // Out-of-range offsets wrap silently; byte lane bits are don't-care.
   assign offset             = req.address - 32'(MEM_BASE);
   assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};
   assign last               = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         word_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      word_d    = word_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      req.ready = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req.ready = ~(req.wr_en | req.rd_en);
            if (req.wr_en || req.rd_en) begin
               wr_d    = req.wr_en;
               word_d  = offset[SRAM_ADDR_W:2];
               wdata_d = req.write_data;
               cnt_d   = '0;
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (last) begin
               if (!wr_q) rdata_d[15:0] = sram_dq;
               cnt_d   = '0;
               state_d = ST_HIGH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (last) begin
               if (!wr_q) rdata_d[31:16] = sram_dq;
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            req.ready = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // DONE keeps the high-half address so the bus is quiet until IDLE.
   always_comb begin
      sram_addr = '0;
      sram_we_n = 1'b1;
      drive     = 1'b0;
      wr_half   = wdata_q[15:0];
      unique case (state_q)
         ST_LOW: begin
            sram_addr = {word_q, 1'b0};
            sram_we_n = ~wr_q;
            drive     = wr_q;
         end
         ST_HIGH: begin
            sram_addr = {word_q, 1'b1};
            sram_we_n = ~wr_q;
            drive     = wr_q;
            wr_half   = wdata_q[31:16];
         end
         ST_DONE: sram_addr = {word_q, 1'b1};
         default: ;
      endcase
   end

   assign sram_dq       = drive ? wr_half : 'z;
   assign req.read_data = rdata_q;
   assign sram_ce_n     = 1'b0;
   assign sram_oe_n     = 1'b0;
   assign sram_ub_n     = 1'b0;
   assign sram_lb_n     = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: three instances (ACCESS_CYCLES 2, 1, 4), each on
// its own behavioural async SRAM, checked against a word-level reference map.
module tb_sram_controller;
   import sram_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]  wr, rd, rdy, swe, tie;
   logic        mdl_en;
   logic [31:0] addr [3];
   logic [31:0] wdata[3];
   logic [31:0] rdata[3];
   logic [17:0] saddr[3];
   logic [15:0] sdq  [3];

   int ncmp = 0;
   int nerr = 0;

   logic [15:0] refm [int unsigned];
   logic [31:0] exp_rd[3];
   logic [31:0] wq[$];

   for (genvar k = 0; k < 3; k++) begin : g
      localparam int unsigned ACK = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
      sram_controller_if bus();
      wire  [15:0] dq;
      logic [17:0] sa;
      logic        we, ce, oe, ub, lb;
      logic [15:0] mem [0:(1<<18)-1];
      logic [17:0] prev_a;
      logic [15:0] prev_d;
      logic        prev_low = 1'b0;

      for (genvar b = 0; b < 16; b++) begin : pu
         pullup (dq[b]);
      end

      assign bus.wr_en      = wr[k];
      assign bus.rd_en      = rd[k];
      assign bus.address    = addr[k];
      assign bus.write_data = wdata[k];
      assign rdata[k] = bus.read_data;
      assign rdy[k]   = bus.ready;
      assign swe[k]   = we;
      assign saddr[k] = sa;
      assign sdq[k]   = dq;
      assign tie[k]   = ce | oe | ub | lb;

      // SRAM output driver: ce/oe are tied low, so it drives whenever we_n=1.
      assign dq = (we && mdl_en) ? mem[sa] : 'z;

      sram_controller #(.ACCESS_CYCLES(ACK)) dut (
         .clk(clk), .rst(rst), .req(bus),
         .sram_dq(dq), .sram_addr(sa), .sram_we_n(we),
         .sram_ce_n(ce), .sram_oe_n(oe), .sram_ub_n(ub), .sram_lb_n(lb)
      );

      always @(posedge clk) begin
         if (!we) mem[sa] <= dq;
      end

      always @(negedge clk) begin
         if (!we && prev_low && sa == prev_a) begin
            ncmp++;
            assert (dq === prev_d) else begin
               nerr++;
               $error("FAIL wr_stable[%0d]: observed %h expected %h", k, dq, prev_d);
            end
         end
         prev_low = !we;
         prev_a   = sa;
         prev_d   = dq;
      end
   end

   function automatic int unsigned acv(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
   endfunction

   function automatic int unsigned word_of(input logic [31:0] a);
      return ((a - 32'd1024) / 4) % (1 << 17);
   endfunction

   function automatic int unsigned key(input int k, input int unsigned idx);
      return k * (1 << 18) + idx;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic txn(input int k, input logic w, input logic r,
                      input logic [31:0] a, input logic [31:0] d);
      int unsigned ac, lowc, lo_idx;
      logic hi;
      ac     = acv(k);
      lo_idx = 2 * word_of(a);
      @(negedge clk);
      wr[k] = w; rd[k] = r; addr[k] = a; wdata[k] = d;
      lowc = 0;
      #1;
      while (!rdy[k] && lowc < 40) begin
         if (lowc == 0) begin
            chk("idle_addr", 32'(saddr[k]), 32'd0);
            chk("idle_we", 32'(swe[k]), 32'd1);
         end else if (lowc <= 2 * ac) begin
            hi = (lowc > ac);
            chk("acc_addr", 32'(saddr[k]), lo_idx + 32'(hi));
            chk("acc_we", 32'(swe[k]), 32'(!w));
            if (w) chk("acc_dq", 32'(sdq[k]), hi ? 32'(d[31:16]) : 32'(d[15:0]));
         end
         lowc++;
         @(negedge clk);
         #1;
      end
      chk("stall_cycles", lowc, 2 * ac + 1);
      if (w) begin
         refm[key(k, lo_idx)]     = d[15:0];
         refm[key(k, lo_idx + 1)] = d[31:16];
      end else if (r) begin
         exp_rd[k] = {refm[key(k, lo_idx + 1)], refm[key(k, lo_idx)]};
      end
      chk("done_rdata", rdata[k], exp_rd[k]);
      chk("done_addr", 32'(saddr[k]), lo_idx + 1);
      chk("done_we", 32'(swe[k]), 32'd1);
      @(posedge clk);
      #1;
      wr[k] = 1'b0; rd[k] = 1'b0;
   endtask

   initial begin
      wr = '0; rd = '0; mdl_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         addr[k] = '0; wdata[k] = '0; exp_rd[k] = '0;
      end
      #2 rst = 1'b0;
      #10;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", 32'(rdy[k]), 32'd1);
         chk("rst_rdata", rdata[k], 32'd0);
         chk("rst_we", 32'(swe[k]), 32'd1);
         chk("rst_addr", 32'(saddr[k]), 32'd0);
         chk("tie_low", 32'(tie[k]), 32'd0);
      end
      @(negedge clk) rst = 1'b1;

      txn(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
      chk("mem_w0", 32'(g[0].mem[0]), 32'h0000BEEF);
      chk("mem_w1", 32'(g[0].mem[1]), 32'h0000DEAD);
      txn(0, 1'b0, 1'b1, 32'd1024, 32'h0);
      repeat (3) @(negedge clk);
      #1 chk("rd_hold", rdata[0], 32'hDEADBEEF);

      txn(0, 1'b1, 1'b0, 32'd1028, 32'h11223344);
      txn(0, 1'b0, 1'b1, 32'd1028, 32'h0);
      chk("b2b_w2", 32'(g[0].mem[2]), 32'h00003344);
      chk("b2b_w3", 32'(g[0].mem[3]), 32'h00001122);

      txn(0, 1'b1, 1'b0, 32'd1031, 32'hA5A55A5A);
      chk("mis_w2", 32'(g[0].mem[2]), 32'h00005A5A);
      chk("mis_w3", 32'(g[0].mem[3]), 32'h0000A5A5);
      txn(0, 1'b1, 1'b1, 32'd1024, 32'h01020304);
      chk("both_rdata", rdata[0], 32'h11223344);
      chk("both_w0", 32'(g[0].mem[0]), 32'h00000304);

      txn(0, 1'b1, 1'b0, 32'd0, 32'hCAFEF00D);
      chk("wrap_lo", 32'(g[0].mem[18'h3FE00]), 32'h0000F00D);
      chk("wrap_hi", 32'(g[0].mem[18'h3FE01]), 32'h0000CAFE);
      txn(0, 1'b0, 1'b1, 32'd2, 32'h0);

      for (int k = 0; k < 3; k++) begin
         wq.delete();
         for (int n = 0; n < 20; n++) begin
            logic        w, r;
            logic [31:0] a, d;
            d = $urandom;
            if (wq.size() == 0 || $urandom_range(0, 2) == 0) begin
               w = 1'b1;
               r = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 1023));
               else                           a = 32'd1024 + 32'($urandom_range(0, 4095));
               wq.push_back(a);
            end else begin
               w = 1'b0;
               r = 1'b1;
               a = (wq[$urandom_range(0, wq.size() - 1)] & ~32'd3) | 32'($urandom_range(0, 3));
            end
            txn(k, w, r, a, d);
         end
      end

      // Abort a write in its high half with an asynchronous reset.
      @(negedge clk);
      wr[0] = 1'b1; rd[0] = 1'b0; addr[0] = 32'd1040; wdata[0] = 32'h12345678;
      repeat (acv(0) + 1) @(negedge clk);
      #1 chk("pre_rst_we", 32'(swe[0]), 32'd0);
      mdl_en = 1'b0;
      #1 rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) exp_rd[k] = '0;
      chk("arst_we", 32'(swe[0]), 32'd1);
      chk("arst_addr", 32'(saddr[0]), 32'd0);
      chk("arst_dq_z", 32'(sdq[0]), 32'h0000FFFF);
      chk("arst_rdata", rdata[0], 32'd0);
      chk("arst_rdata_k2", rdata[2], 32'd0);
      chk("arst_ready_req", 32'(rdy[0]), 32'd0);
      wr[0] = 1'b0;
      #1 chk("arst_ready_idle", 32'(rdy[0]), 32'd1);
      @(negedge clk);
      rst = 1'b1; mdl_en = 1'b1;
      txn(0, 1'b0, 1'b1, 32'd1024, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Responder side of the MEM-stage data-memory request.
- Accepts one 32-bit read or write per request.
- Services it as two 16-bit accesses on an external asynchronous SRAM: low half first, then high half.
- Holds `ready` low until done, so the pipeline freeze logic stalls IF/ID/EXE/MEM while `ready=0`.

Parameters:
- `ACCESS_CYCLES`, 2, clock cycles each 16-bit SRAM access is held (≥1).
- `MEM_BASE`, 1024, byte address mapped to SRAM word 0.
- `SRAM_ADDR_W`, 18, external SRAM address width (16-bit words).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request from MEM stage.
- `rd_en`  in  1  read request from MEM stage.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Rm value).
- `read_data`  out  32  registered load result.
- `ready`  out  1  1 = no request outstanding or request complete this cycle; 0 = stall.
- `sram_dq`  inout  16  SRAM data bus.
- `sram_addr`  out  `SRAM_ADDR_W`  SRAM word address.
- `sram_we_n`  out  1  SRAM write enable, active low.
- `sram_ce_n`, `sram_oe_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  tied 0.

Behaviour:
- **Address mapping**
  - `offset = address - MEM_BASE` (32-bit wrap).
  - `word = offset[SRAM_ADDR_W:2]`.
  - Low half at `sram_addr = {word, 1'b0}`; high half at `{word, 1'b1}`.
  - `address[1:0]` is ignored. Out-of-range offsets wrap silently, with no error flag.
- **States:** IDLE, LOW, HIGH, DONE, plus a wait counter `cnt` (0..`ACCESS_CYCLES`-1).
  - IDLE: if `wr_en` or `rd_en`, latch op/word/`write_data`, `cnt<=0`, go LOW.
  - LOW: when `cnt==ACCESS_CYCLES-1`, go HIGH and `cnt<=0`; else `cnt++`.
  - HIGH: same counting rule, exit to DONE.
  - DONE: unconditionally go to IDLE.
- **Request priority:** if `wr_en` and `rd_en` are both 1, the write wins and no read is performed.
- **ready (combinational)**
  - IDLE: `ready = ~(wr_en | rd_en)`.
  - LOW/HIGH: `ready = 0`.
  - DONE: `ready = 1`.
  - The pipeline advances at the DONE clock edge. The next request is seen in IDLE one cycle later.
- **Latency:** a request first seen at cycle 0 holds `ready` low for cycles 0..2·`ACCESS_CYCLES`, and `ready=1` at cycle 2·`ACCESS_CYCLES`+1. With the default, `ready` is low for 5 cycles and high on the 6th.
- **Writes**
  - `sram_we_n=0` throughout LOW and HIGH.
  - `sram_dq` carries `write_data[15:0]` in LOW and `write_data[31:16]` in HIGH.
  - `sram_we_n=1` in IDLE and DONE.
- **Reads**
  - `sram_dq` is high-Z.
  - `read_data[15:0]` captures `sram_dq` on the last LOW cycle edge; `read_data[31:16]` on the last HIGH cycle edge.
  - `read_data` is valid in DONE and holds until the next read completes. Writes do not alter it.
- **`sram_dq` drive:** driven only in LOW/HIGH of a write; high-Z otherwise.
- **`sram_addr`:** 0 in IDLE, held in DONE.
- **Reset (async, any state, including mid-access):**
  - state IDLE, `cnt` 0, `read_data` 0, `sram_we_n` 1, `sram_dq` high-Z, `sram_addr` 0.
  - `ready` follows the IDLE rule.
  - An aborted write may leave one half written; this is accepted.
- **Request changes:** requests must be held stable while `ready=0`. Changes during LOW/HIGH are ignored because the values are latched.

Decomposition:
- Shared package (`sram_pkg`):
  - state encoding (2-bit: IDLE/LOW/HIGH/DONE);
  - `MEM_BASE`;
  - `SRAM_DATA_W=16`;
  - `SRAM_ADDR_W=18`.
- No RTL sub-module.
- Bench-only behavioural model `sram_model`: 2^18 × 16 array with asynchronous read and write on `we_n` low. It checks that `address` and data are stable while `we_n` is low.

Test Plan:
- **Write:** `wr_en=1`, `address=1024`, `write_data=0xDEADBEEF`.
  - Model word 0 = 0xBEEF, word 1 = 0xDEAD.
  - `ready` low 5 cycles, high on cycle 5.
- **Read-back:** `rd_en=1`, `address=1024` after the write test → `read_data=0xDEADBEEF` in DONE; held after `rd_en` drops.
- **Back-to-back:**
  - write 0x11223344 to 1028, then immediately read 1028;
  - the second request enters IDLE the cycle after DONE;
  - read returns 0x11223344; words 2 and 3 are 0x3344 and 0x1122.
- **Misaligned and simultaneous:**
  - `address=1031` writes words 2 and 3, same as 1028;
  - `wr_en=rd_en=1` performs the write and leaves `read_data` unchanged.
- **Reset mid-write:**
  - assert `rst=0` during HIGH;
  - immediately `sram_we_n=1`, `sram_dq`=Z, `read_data=0`, state IDLE;
  - with no request, `ready=1`.
- **Param sweep:** `ACCESS_CYCLES=1` and `4` → `ready` low for 3 and 9 cycles; data correct.
